// File: rtl/ex_divider_pkg.sv
// Shared types and constants for the EX-stage divide/remainder unit.
package ex_divider_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    // Bit positions within the packed {is_signed, is_rem, is_word} request mode.
    localparam int unsigned OP_SIGNED = 2;
    localparam int unsigned OP_REM    = 1;
    localparam int unsigned OP_WORD   = 0;
    typedef logic [2:0] div_op_t;

    localparam logic [XLEN-1:0] ALL_ONES  = '1;
    localparam logic [XLEN-1:0] INT_MIN64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] INT_MIN32 = {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_word(input logic [WORD_W-1:0] v);
        return {{(XLEN-WORD_W){v[WORD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract divisor.
module ex_div_step
    import ex_divider_pkg::*;
#(
    parameter int unsigned Width = XLEN
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] divisor_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] shifted;
    logic [Width:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[Width-1]};
        diff    = shifted - {1'b0, divisor_i};
        // rem < divisor always holds, so bit Width of diff is set exactly on a borrow.
        if (diff[Width]) begin
            rem_o = shifted[Width-1:0];
            quo_o = {quo_i[Width-2:0], 1'b0};
        end else begin
            rem_o = diff[Width-1:0];
            quo_o = {quo_i[Width-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_divider.sv
// Iterative RV64M divide/remainder unit: one request in, N restoring steps, one result out.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int unsigned Xlen = XLEN,
    parameter int unsigned CntW = CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Xlen-1:0] dividend,
    input  logic [Xlen-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Xlen-1:0] result
);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [Xlen-1:0] rem_q, rem_d;
    logic [Xlen-1:0] quo_q, quo_d;
    logic [Xlen-1:0] dvs_q, dvs_d;
    logic            rem_sel_q, rem_sel_d;
    logic            word_q, word_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [Xlen-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;

    div_op_t         op_in;
    logic [Xlen-1:0] op_a, op_b, mag_a, mag_b;
    logic            a_neg, b_neg, div_zero, overflow;
    logic [Xlen-1:0] spec_sel, spec_res;
    logic [Xlen-1:0] step_rem, step_quo;
    logic [Xlen-1:0] q_fin, r_fin, calc_sel, calc_res;

    assign op_in = {is_signed, is_rem, is_word};

    // Operand preparation and special-case detection for the request on the inputs.
    always_comb begin
        if (op_in[OP_WORD]) begin
            op_a = op_in[OP_SIGNED] ? sext_word(dividend[WORD_W-1:0])
                                    : {{(Xlen-WORD_W){1'b0}}, dividend[WORD_W-1:0]};
            op_b = op_in[OP_SIGNED] ? sext_word(divisor[WORD_W-1:0])
                                    : {{(Xlen-WORD_W){1'b0}}, divisor[WORD_W-1:0]};
        end else begin
            op_a = dividend;
            op_b = divisor;
        end
        a_neg    = op_in[OP_SIGNED] & op_a[Xlen-1];
        b_neg    = op_in[OP_SIGNED] & op_b[Xlen-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        div_zero = (op_b == '0);
        overflow = op_in[OP_SIGNED] & (op_b == ALL_ONES)
                 & (op_in[OP_WORD] ? (op_a == INT_MIN32) : (op_a == INT_MIN64));
        if (div_zero) begin
            spec_sel = op_in[OP_REM] ? op_a : ALL_ONES;
        end else begin
            spec_sel = op_in[OP_REM] ? '0 : op_a;
        end
        spec_res = op_in[OP_WORD] ? sext_word(spec_sel[WORD_W-1:0]) : spec_sel;
    end

    ex_div_step #(
        .Width(Xlen)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    // Final result built from the last step's outputs, used on the CALC->DONE edge.
    always_comb begin
        q_fin    = q_neg_q ? -step_quo : step_quo;
        r_fin    = r_neg_q ? -step_rem : step_rem;
        calc_sel = rem_sel_q ? r_fin : q_fin;
        calc_res = word_q ? sext_word(calc_sel[WORD_W-1:0]) : calc_sel;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_sel_d   = rem_sel_q;
        word_d      = word_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rem_sel_d = op_in[OP_REM];
                        word_d    = op_in[OP_WORD];
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        dvs_d     = mag_b;
                        rem_d     = '0;
                        // Word ops park the 32-bit magnitude in the top half so N=32 steps suffice.
                        quo_d     = op_in[OP_WORD] ? (mag_a << WORD_W) : mag_a;
                        cnt_d     = op_in[OP_WORD] ? CntW'(WORD_W - 1) : CntW'(Xlen - 1);
                        if (div_zero || overflow) begin
                            state_d     = StDone;
                            out_valid_d = 1'b1;
                            result_d    = spec_res;
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        cnt_d       = '0;
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        result_d    = calc_res;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_sel_q   <= 1'b0;
            word_q      <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_sel_q   <= rem_sel_d;
            word_q      <= word_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: reference model feeds a scoreboard of results and latencies.
module tb_ex_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        is_rem = 1'b0;
    logic        is_word = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        r;
        logic        w;
    } vec_t;

    ex_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .is_signed(is_signed),
        .is_rem   (is_rem),
        .is_word  (is_word),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_div(logic [63:0] a, logic [63:0] b, logic s, logic r,
                                            logic w);
        logic [63:0] q, m;
        logic [31:0] a32, b32, q32, m32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin q32 = '1; m32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; m32 = '0; end
            else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                m32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                m32 = a32 % b32;
            end
            r32 = r ? m32 : q32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) begin q = '1; m = a; end
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; m = '0; end
        else if (s) begin
            q = $signed(a) / $signed(b);
            m = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            m = a % b;
        end
        return r ? m : q;
    endfunction

    function automatic int ref_lat(logic [63:0] a, logic [63:0] b, logic s, logic w);
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic r, input logic w);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        is_rem    = r;
        is_word   = w;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_result(output logic [63:0] got, output int lat, output bit tmo);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tmo = !out_valid;
        got = result;
    endtask

    task automatic do_op(input vec_t v, output logic [63:0] got, output int lat, output bit tmo);
        exp_q.push_back(ref_div(v.a, v.b, v.s, v.r, v.w));
        lat_q.push_back(ref_lat(v.a, v.b, v.s, v.w));
        out_ready = 1'b1;
        issue(v.a, v.b, v.s, v.r, v.w);
        wait_result(got, lat, tmo);
        if (!tmo) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h, want 1 0 0",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        vec_t v[$];
        logic [63:0] got, exp_r;
        int lat, exp_l;
        bit tmo;
        v = '{'{64'd100, 64'd7, 1'b0, 1'b0, 1'b0}, '{64'd100, 64'd7, 1'b0, 1'b1, 1'b0},
              '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b1, 1'b0}};
        foreach (v[i]) begin
            do_op(v[i], got, lat, tmo);
            exp_r = exp_q.pop_front();
            exp_l = lat_q.pop_front();
            vectors++;
            if (tmo) begin miscompares++; $display("FAIL unsigned[%0d] timeout", i); end
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL unsigned[%0d] result: got %h want %h", i, got, exp_r);
            end
            vectors++;
            if (lat !== exp_l) begin
                miscompares++;
                $display("FAIL unsigned[%0d] latency: got %0d want %0d", i, lat, exp_l);
            end
        end
    endtask

    task automatic test_signed();
        vec_t v[$];
        logic [63:0] got, exp_r;
        int lat, exp_l;
        bit tmo;
        v = '{'{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0},
              '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0},
              '{64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0},
              '{64'h8000_0000_0000_0000, 64'd7, 1'b1, 1'b1, 1'b0}};
        foreach (v[i]) begin
            do_op(v[i], got, lat, tmo);
            exp_r = exp_q.pop_front();
            exp_l = lat_q.pop_front();
            vectors++;
            if (tmo) begin miscompares++; $display("FAIL signed[%0d] timeout", i); end
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL signed[%0d] result: got %h want %h", i, got, exp_r);
            end
            vectors++;
            if (lat !== exp_l) begin
                miscompares++;
                $display("FAIL signed[%0d] latency: got %0d want %0d", i, lat, exp_l);
            end
        end
    endtask

    task automatic test_special();
        vec_t v[$];
        logic [63:0] got, exp_r;
        int lat, exp_l;
        bit tmo;
        v = '{'{64'd5, 64'd0, 1'b0, 1'b0, 1'b0}, '{64'd5, 64'd0, 1'b0, 1'b1, 1'b0},
              '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0},
              '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0},
              '{64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 1'b1, 1'b1, 1'b0}};
        foreach (v[i]) begin
            do_op(v[i], got, lat, tmo);
            exp_r = exp_q.pop_front();
            exp_l = lat_q.pop_front();
            vectors++;
            if (tmo) begin miscompares++; $display("FAIL special[%0d] timeout", i); end
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL special[%0d] result: got %h want %h", i, got, exp_r);
            end
            vectors++;
            if (lat !== exp_l) begin
                miscompares++;
                $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, exp_l);
            end
        end
    endtask

    task automatic test_word();
        vec_t v[$];
        logic [63:0] got, exp_r;
        int lat, exp_l;
        bit tmo;
        v = '{'{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1},
              '{64'h0000_0001_0000_0010, 64'd4, 1'b0, 1'b0, 1'b1},
              '{64'h1234_5678_FFFF_FF00, 64'd7, 1'b1, 1'b1, 1'b1},
              '{64'h0000_0000_F000_0001, 64'd3, 1'b0, 1'b0, 1'b1},
              '{64'h0000_0000_8000_0007, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, 1'b1}};
        foreach (v[i]) begin
            do_op(v[i], got, lat, tmo);
            exp_r = exp_q.pop_front();
            exp_l = lat_q.pop_front();
            vectors++;
            if (tmo) begin miscompares++; $display("FAIL word[%0d] timeout", i); end
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL word[%0d] result: got %h want %h", i, got, exp_r);
            end
            vectors++;
            if (lat !== exp_l) begin
                miscompares++;
                $display("FAIL word[%0d] latency: got %0d want %0d", i, lat, exp_l);
            end
        end
    endtask

    task automatic test_random();
        vec_t v;
        logic [63:0] got, exp_r;
        int lat, exp_l;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            v.a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: v.b = 64'd0;
                1: v.b = {32'd0, $urandom};
                2: v.b = {{61{v.a[5]}}, 3'($urandom_range(1, 7))};
                default: v.b = {$urandom, $urandom};
            endcase
            v.s = 1'($urandom_range(0, 1));
            v.r = 1'($urandom_range(0, 1));
            v.w = 1'($urandom_range(0, 1));
            do_op(v, got, lat, tmo);
            exp_r = exp_q.pop_front();
            exp_l = lat_q.pop_front();
            vectors++;
            if (tmo) begin miscompares++; $display("FAIL random[%0d] timeout", i); end
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL random[%0d] result %h/%h s%0d r%0d w%0d: got %h want %h",
                         i, v.a, v.b, v.s, v.r, v.w, got, exp_r);
            end
            vectors++;
            if (lat !== exp_l) begin
                miscompares++;
                $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, exp_l);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] got, exp_r;
        int lat;
        bit tmo;
        exp_q.push_back(ref_div(64'd100, 64'd7, 1'b0, 1'b0, 1'b0));
        out_ready = 1'b0;
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_result(got, lat, tmo);
        exp_r = exp_q.pop_front();
        vectors++;
        if (tmo || got !== exp_r) begin
            miscompares++;
            $display("FAIL backpressure result: got %h (timeout=%0d) want %h", got, tmo, exp_r);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = 64'd5;
            divisor  = 64'd0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure hold[%0d]: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                         i, out_valid, result, in_ready, exp_r);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure handoff: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure ignored-request: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        bit seen;
        out_ready = 1'b1;
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush calc: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL flush dropped-result: out_valid seen=1 want 0");
        end
        // A divide-by-zero request would complete in one cycle if it were accepted.
        @(negedge clk);
        dividend = 64'd5;
        divisor  = 64'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush idle-accept: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end
        out_ready = 1'b0;
        issue(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush setup-done: out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush done: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 1'b1;
        issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || result !== 64'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset mid-calc: out_valid=%b result=%h in_ready=%b, want 0 0 1",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset discarded-op: out_valid seen=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_word();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_divider.md
Name: ex_divider

Overview:
Multi-cycle 64-bit integer divide/remainder unit in the EX stage, alongside the single-cycle ALU. It executes the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW operations, which the ALU cannot complete in one cycle. It accepts one request via a valid/ready handshake, iterates a radix-2 restoring division, and returns the result via a second valid/ready handshake. A pipeline flush aborts an in-flight operation.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.
CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request (IDLE state)
dividend  in  64  rs1 value
divisor  in  64  rs2 value
is_signed  in  1  1 = DIV/REM family, 0 = unsigned
is_rem  in  1  1 = return remainder, 0 = quotient
is_word  in  1  1 = *W variant (32-bit op, sign-extended result)
flush  in  1  abort current operation, drop pending result
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  64  quotient or remainder

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, result=0, counter=0, internal registers cleared; in_ready=1 after reset. Reset mid-operation discards the operation.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE), combinational from state only.
- Accept: in_valid & in_ready & ~flush at edge. Latch mode bits and operands. For is_word, use low 32 bits, sign-extended (signed) or zero-extended (unsigned), and set N=32; otherwise N=64. Signed ops store magnitudes plus quotient sign (sd^sv) and remainder sign (sd).
- Special cases detected at accept go IDLE->DONE directly (out_valid next cycle):
  divide by zero -> quotient all-ones (2^N-1 before extension), remainder = dividend;
  signed overflow (most-negative / -1, N-bit) -> quotient = dividend, remainder = 0.
- Normal: IDLE->CALC. Each CALC cycle performs one restoring step: shift {rem,quo} left by 1, trial-subtract divisor, keep the difference and set the quotient bit if there is no borrow. Counter counts N steps. On the last step: CALC->DONE, apply sign correction, select quotient/remainder, and for is_word sign-extend bit 31 to 64 bits.
- Latency: out_valid rises exactly N+1 cycles after the accept edge (65 for 64-bit, 33 for word); 1 cycle for special cases.
- DONE: out_valid=1, result held stable until out_valid & out_ready, then DONE->IDLE. A new request can be accepted the following cycle at the earliest; there is no accept in the same cycle as the handoff.
- flush: from any state, next state=IDLE and out_valid=0. flush takes priority over accept and over out_ready in the same cycle.
- Result register is updated only on entry to DONE.

Decomposition:
- Shared package: XLEN, state enum (IDLE/CALC/DONE), op-bit positions {is_signed,is_rem,is_word}, special-case constants (all-ones, INT_MIN for 32/64).
- One sub-module: ex_div_step. It is combinational and performs one restoring iteration (inputs: partial remainder, quotient, divisor; outputs: next remainder, next quotient). It is instantiated once inside the iterative FSM.

Test Plan:
- DIVU 100/7: accept, out_ready=1 -> result 14 with out_valid exactly 65 cycles after accept; REMU 100/7 -> 2.
- DIV 0xFFFFFFFFFFFFFFF9 / 2 -> 0xFFFFFFFFFFFFFFFD; REM same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFFFFFFFFFF and REMU 5/0 -> 5, each in 1 cycle; DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000, REM -> 0.
- DIVW dividend 0x0000000080000000, divisor 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000 (1 cycle). DIVUW 0x0000000100000010 / 4 -> 0x4 at 33 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, and in_valid ignored; out_ready=1 -> handoff, then in_ready=1 next cycle.
- flush at CALC cycle 10, and flush concurrent with in_valid in IDLE -> IDLE next cycle, no out_valid, no accept. Reset asserted mid-CALC -> out_valid=0 and result=0.
